// File: rtl/wb_queue_if.sv
// Write-back queue bus: producer pushes, register-file write port, bypass queries, status.
interface wb_queue_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          WB_alu_valid;
    logic [4:0]    WB_alu_addr;
    logic [31:0]   WB_alu_data;
    logic          WB_ld_valid;
    logic [4:0]    WB_ld_addr;
    logic [31:0]   WB_ld_data;
    logic          WB_ready;
    logic          REG_write_1;
    logic [4:0]    REG_address_wr;
    logic [31:0]   REG_data_wb_in1;
    logic [4:0]    WB_q_addr_1;
    logic [4:0]    WB_q_addr_2;
    logic          WB_q_hit_1;
    logic          WB_q_hit_2;
    logic [31:0]   WB_q_data_1;
    logic [31:0]   WB_q_data_2;
    logic [CW-1:0] WB_count;
    logic          WB_overflow;

    modport master (
        output WB_alu_valid, WB_alu_addr, WB_alu_data,
        output WB_ld_valid, WB_ld_addr, WB_ld_data,
        output WB_q_addr_1, WB_q_addr_2,
        input  WB_ready, REG_write_1, REG_address_wr, REG_data_wb_in1,
        input  WB_q_hit_1, WB_q_hit_2, WB_q_data_1, WB_q_data_2,
        input  WB_count, WB_overflow
    );

    modport slave (
        input  WB_alu_valid, WB_alu_addr, WB_alu_data,
        input  WB_ld_valid, WB_ld_addr, WB_ld_data,
        input  WB_q_addr_1, WB_q_addr_2,
        output WB_ready, REG_write_1, REG_address_wr, REG_data_wb_in1,
        output WB_q_hit_1, WB_q_hit_2, WB_q_data_1, WB_q_data_2,
        output WB_count, WB_overflow
    );
endinterface

// File: rtl/wb_queue.sv
// Write-back queue feeding the single register-file write port, with bypass lookup.
// Optional feature macro: WB_BYPASS_EN (bypass search compiled in when defined).
module wb_queue #(
    parameter int DEPTH = 4
) (
    input logic      clk,
    input logic      rst_n,
    wb_queue_if.slave wb
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } entry_t;

    entry_t        mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          reg_write_r;
    logic [4:0]    reg_addr_r;
    logic [31:0]   reg_data_r;
    logic          overflow_r;

    logic          alu_ok_s;
    logic          ld_ok_s;
    logic          alu_acc_s;
    logic          ld_acc_s;
    logic          drop_s;
    logic          pop_s;
    logic [CW-1:0] free_s;
    logic [CW-1:0] push_n_s;
    logic [CW-1:0] count_nxt_s;
    logic [PW-1:0] ld_ptr_s;

    // Push acceptance: space is judged before the same-cycle pop, ALU takes the first free slot.
    always_comb begin
        alu_ok_s    = wb.WB_alu_valid && (wb.WB_alu_addr != 5'd0);
        ld_ok_s     = wb.WB_ld_valid && (wb.WB_ld_addr != 5'd0);
        free_s      = CW'(DEPTH) - count_r;
        alu_acc_s   = alu_ok_s && (free_s >= CW'(1));
        ld_acc_s    = ld_ok_s && (free_s >= (alu_acc_s ? CW'(2) : CW'(1)));
        drop_s      = (alu_ok_s && !alu_acc_s) || (ld_ok_s && !ld_acc_s);
        pop_s       = (count_r != {CW{1'b0}});
        push_n_s    = {{(CW-1){1'b0}}, alu_acc_s} + {{(CW-1){1'b0}}, ld_acc_s};
        count_nxt_s = count_r + push_n_s - {{(CW-1){1'b0}}, pop_s};
        ld_ptr_s    = alu_acc_s ? (wr_ptr_r + PW'(1)) : wr_ptr_r;
    end

    // Queue storage, pointers, output stage and sticky overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r    <= {PW{1'b0}};
            rd_ptr_r    <= {PW{1'b0}};
            count_r     <= {CW{1'b0}};
            reg_write_r <= 1'b0;
            reg_addr_r  <= 5'd0;
            reg_data_r  <= 32'd0;
            overflow_r  <= 1'b0;
        end else begin
            if (alu_acc_s) begin
                mem_r[wr_ptr_r] <= {wb.WB_alu_addr, wb.WB_alu_data};
            end
            if (ld_acc_s) begin
                mem_r[ld_ptr_s] <= {wb.WB_ld_addr, wb.WB_ld_data};
            end
            if (pop_s) begin
                reg_write_r <= 1'b1;
                reg_addr_r  <= mem_r[rd_ptr_r].addr;
                reg_data_r  <= mem_r[rd_ptr_r].data;
                rd_ptr_r    <= rd_ptr_r + PW'(1);
            end else begin
                reg_write_r <= 1'b0;
            end
            wr_ptr_r <= wr_ptr_r + PW'(push_n_s);
            count_r  <= count_nxt_s;
            if (drop_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    assign wb.WB_ready        = (free_s >= CW'(2));
    assign wb.REG_write_1     = reg_write_r;
    assign wb.REG_address_wr  = reg_addr_r;
    assign wb.REG_data_wb_in1 = reg_data_r;
    assign wb.WB_count        = count_r;
    assign wb.WB_overflow     = overflow_r;

`ifdef WB_BYPASS_EN
    // Oldest-to-youngest scan so later matches override: youngest pending write wins.
    function automatic logic [32:0] bypass_search(
        input logic [4:0]    q,
        input entry_t        m [DEPTH],
        input logic [PW-1:0] rd,
        input logic [CW-1:0] cnt,
        input logic          out_vld,
        input logic [4:0]    out_addr,
        input logic [31:0]   out_data
    );
        logic [32:0]   res;
        logic [PW-1:0] idx;
        res = 33'd0;
        if (q != 5'd0) begin
            if (out_vld && (out_addr == q)) begin
                res = {1'b1, out_data};
            end else begin
                res = 33'd0;
            end
            for (int k = 0; k < DEPTH; k++) begin
                idx = rd + PW'(k);
                if ((CW'(k) < cnt) && (m[idx].addr == q)) begin
                    res = {1'b1, m[idx].data};
                end
            end
        end else begin
            res = 33'd0;
        end
        return res;
    endfunction

    logic [32:0] look_1_s;
    logic [32:0] look_2_s;

    assign look_1_s = bypass_search(wb.WB_q_addr_1, mem_r, rd_ptr_r, count_r,
                                    reg_write_r, reg_addr_r, reg_data_r);
    assign look_2_s = bypass_search(wb.WB_q_addr_2, mem_r, rd_ptr_r, count_r,
                                    reg_write_r, reg_addr_r, reg_data_r);

    assign wb.WB_q_hit_1  = look_1_s[32];
    assign wb.WB_q_data_1 = look_1_s[31:0];
    assign wb.WB_q_hit_2  = look_2_s[32];
    assign wb.WB_q_data_2 = look_2_s[31:0];
`else
    // Without bypass, decode stalls on WB_count/REG_write_1 instead; query addresses go unused.
    logic unused_q_s;
    assign unused_q_s     = ^{wb.WB_q_addr_1, wb.WB_q_addr_2};
    assign wb.WB_q_hit_1  = 1'b0;
    assign wb.WB_q_data_1 = 32'd0;
    assign wb.WB_q_hit_2  = 1'b0;
    assign wb.WB_q_data_2 = 32'd0;
`endif

endmodule

// File: tb/tb_wb_queue.sv
// Directed self-checking bench for wb_queue (DEPTH=4); expectations follow the bypass build option.
module tb_wb_queue;
`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    wb_queue_if #(.DEPTH(4)) bus ();

    wb_queue #(.DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .wb    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.WB_alu_valid = 1'b0;
        bus.WB_alu_addr  = 5'd0;
        bus.WB_alu_data  = 32'd0;
        bus.WB_ld_valid  = 1'b0;
        bus.WB_ld_addr   = 5'd0;
        bus.WB_ld_data   = 32'd0;
    endtask

    task automatic push_alu(input logic [4:0] a, input logic [31:0] d);
        bus.WB_alu_valid = 1'b1;
        bus.WB_alu_addr  = a;
        bus.WB_alu_data  = d;
    endtask

    task automatic push_ld(input logic [4:0] a, input logic [31:0] d);
        bus.WB_ld_valid = 1'b1;
        bus.WB_ld_addr  = a;
        bus.WB_ld_data  = d;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        bus.WB_q_addr_1 = 5'd0;
        bus.WB_q_addr_2 = 5'd0;
        #12;
        checks++; if (bus.WB_count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", bus.WB_count); end
        checks++; if (bus.REG_write_1 !== 1'b0) begin failures++; $display("FAIL reset_write got=%b exp=0", bus.REG_write_1); end
        checks++; if (bus.REG_address_wr !== 5'd0) begin failures++; $display("FAIL reset_addr got=%0d exp=0", bus.REG_address_wr); end
        checks++; if (bus.REG_data_wb_in1 !== 32'd0) begin failures++; $display("FAIL reset_data got=%h exp=0", bus.REG_data_wb_in1); end
        checks++; if (bus.WB_overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", bus.WB_overflow); end
        checks++; if (bus.WB_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", bus.WB_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        push_alu(5'd5, 32'hDEADBEEF);
        bus.WB_q_addr_1 = 5'd5;
        step();
        idle();
        checks++; if (bus.WB_count !== 3'd1) begin failures++; $display("FAIL single_e1_count got=%0d exp=1", bus.WB_count); end
        checks++; if (bus.REG_write_1 !== 1'b0) begin failures++; $display("FAIL single_e1_write got=%b exp=0", bus.REG_write_1); end
        checks++; if (bus.WB_q_hit_1 !== BYP) begin failures++; $display("FAIL single_e1_hit got=%b exp=%b", bus.WB_q_hit_1, BYP); end
        checks++; if (bus.WB_q_data_1 !== (BYP ? 32'hDEADBEEF : 32'd0)) begin failures++; $display("FAIL single_e1_qdata got=%h", bus.WB_q_data_1); end
        step();
        checks++; if (bus.REG_write_1 !== 1'b1) begin failures++; $display("FAIL single_e2_write got=%b exp=1", bus.REG_write_1); end
        checks++; if (bus.REG_address_wr !== 5'd5) begin failures++; $display("FAIL single_e2_addr got=%0d exp=5", bus.REG_address_wr); end
        checks++; if (bus.REG_data_wb_in1 !== 32'hDEADBEEF) begin failures++; $display("FAIL single_e2_data got=%h exp=deadbeef", bus.REG_data_wb_in1); end
        checks++; if (bus.WB_q_hit_1 !== BYP) begin failures++; $display("FAIL single_e2_hit got=%b exp=%b", bus.WB_q_hit_1, BYP); end
        step();
        checks++; if (bus.REG_write_1 !== 1'b0) begin failures++; $display("FAIL single_e3_write got=%b exp=0", bus.REG_write_1); end
        checks++; if (bus.WB_count !== 3'd0) begin failures++; $display("FAIL single_e3_count got=%0d exp=0", bus.WB_count); end
        checks++; if (bus.WB_q_hit_1 !== 1'b0) begin failures++; $display("FAIL single_e3_hit got=%b exp=0", bus.WB_q_hit_1); end
    endtask

    task automatic test_dual_same_addr();
        push_alu(5'd3, 32'h11);
        push_ld(5'd3, 32'h22);
        bus.WB_q_addr_1 = 5'd3;
        bus.WB_q_addr_2 = 5'd3;
        step();
        idle();
        checks++; if (bus.WB_count !== 3'd2) begin failures++; $display("FAIL dual_e1_count got=%0d exp=2", bus.WB_count); end
        checks++; if (bus.WB_q_hit_2 !== BYP) begin failures++; $display("FAIL dual_e1_hit got=%b exp=%b", bus.WB_q_hit_2, BYP); end
        checks++; if (bus.WB_q_data_2 !== (BYP ? 32'h22 : 32'd0)) begin failures++; $display("FAIL dual_e1_qdata got=%h", bus.WB_q_data_2); end
        step();
        checks++; if (bus.REG_write_1 !== 1'b1 || bus.REG_data_wb_in1 !== 32'h11) begin failures++; $display("FAIL dual_e2_first_write got=%b/%h exp=1/11", bus.REG_write_1, bus.REG_data_wb_in1); end
        checks++; if (bus.WB_q_data_1 !== (BYP ? 32'h22 : 32'd0)) begin failures++; $display("FAIL dual_e2_qdata got=%h", bus.WB_q_data_1); end
        step();
        checks++; if (bus.REG_write_1 !== 1'b1 || bus.REG_data_wb_in1 !== 32'h22) begin failures++; $display("FAIL dual_e3_second_write got=%b/%h exp=1/22", bus.REG_write_1, bus.REG_data_wb_in1); end
        checks++; if (bus.REG_address_wr !== 5'd3) begin failures++; $display("FAIL dual_e3_addr got=%0d exp=3", bus.REG_address_wr); end
        checks++; if (bus.WB_q_data_1 !== (BYP ? 32'h22 : 32'd0)) begin failures++; $display("FAIL dual_e3_qdata got=%h", bus.WB_q_data_1); end
        step();
        checks++; if (bus.WB_q_hit_1 !== 1'b0 || bus.WB_q_hit_2 !== 1'b0) begin failures++; $display("FAIL dual_e4_nohit got=%b%b exp=00", bus.WB_q_hit_1, bus.WB_q_hit_2); end
        checks++; if (bus.REG_write_1 !== 1'b0) begin failures++; $display("FAIL dual_e4_write got=%b exp=0", bus.REG_write_1); end
    endtask

    task automatic test_addr_zero();
        push_alu(5'd0, 32'hFFFFFFFF);
        bus.WB_q_addr_1 = 5'd0;
        step();
        idle();
        checks++; if (bus.WB_count !== 3'd0) begin failures++; $display("FAIL zero_count got=%0d exp=0", bus.WB_count); end
        checks++; if (bus.WB_overflow !== 1'b0) begin failures++; $display("FAIL zero_overflow got=%b exp=0", bus.WB_overflow); end
        checks++; if (bus.WB_q_hit_1 !== 1'b0 || bus.WB_q_data_1 !== 32'd0) begin failures++; $display("FAIL zero_query got=%b/%h exp=0/0", bus.WB_q_hit_1, bus.WB_q_data_1); end
        step();
        checks++; if (bus.REG_write_1 !== 1'b0) begin failures++; $display("FAIL zero_write got=%b exp=0", bus.REG_write_1); end
    endtask

    task automatic test_fill_overflow();
        logic [4:0]  exp_a [4];
        logic [31:0] exp_d [4];
        exp_a[0] = 5'd3; exp_d[0] = 32'h303;
        exp_a[1] = 5'd4; exp_d[1] = 32'h404;
        exp_a[2] = 5'd5; exp_d[2] = 32'h505;
        exp_a[3] = 5'd0; exp_d[3] = 32'h505;
        push_alu(5'd1, 32'h101);
        push_ld(5'd2, 32'h202);
        bus.WB_q_addr_1 = 5'd6;
        step();
        checks++; if (bus.WB_count !== 3'd2 || bus.WB_ready !== 1'b1) begin failures++; $display("FAIL fill_e1 got=%0d/%b exp=2/1", bus.WB_count, bus.WB_ready); end
        push_alu(5'd3, 32'h303);
        push_ld(5'd4, 32'h404);
        step();
        checks++; if (bus.WB_count !== 3'd3) begin failures++; $display("FAIL fill_e2_count got=%0d exp=3", bus.WB_count); end
        checks++; if (bus.WB_ready !== 1'b0) begin failures++; $display("FAIL fill_e2_ready got=%b exp=0", bus.WB_ready); end
        checks++; if (bus.REG_address_wr !== 5'd1 || bus.REG_data_wb_in1 !== 32'h101) begin failures++; $display("FAIL fill_e2_write got=%0d/%h exp=1/101", bus.REG_address_wr, bus.REG_data_wb_in1); end
        checks++; if (bus.WB_overflow !== 1'b0) begin failures++; $display("FAIL fill_e2_overflow got=%b exp=0", bus.WB_overflow); end
        push_alu(5'd5, 32'h505);
        push_ld(5'd6, 32'h606);
        step();
        idle();
        checks++; if (bus.WB_overflow !== 1'b1) begin failures++; $display("FAIL fill_e3_overflow got=%b exp=1", bus.WB_overflow); end
        checks++; if (bus.WB_count !== 3'd3) begin failures++; $display("FAIL fill_e3_count got=%0d exp=3", bus.WB_count); end
        checks++; if (bus.REG_address_wr !== 5'd2 || bus.REG_data_wb_in1 !== 32'h202) begin failures++; $display("FAIL fill_e3_write got=%0d/%h exp=2/202", bus.REG_address_wr, bus.REG_data_wb_in1); end
        checks++; if (bus.WB_q_hit_1 !== 1'b0) begin failures++; $display("FAIL fill_dropped_hit got=%b exp=0", bus.WB_q_hit_1); end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (bus.REG_write_1 !== (i < 3) || bus.REG_address_wr !== exp_a[i] && i < 3 || bus.REG_data_wb_in1 !== exp_d[i]) begin
                failures++;
                $display("FAIL fill_drain_%0d got=%b/%0d/%h exp=%b/%0d/%h", i, bus.REG_write_1, bus.REG_address_wr, bus.REG_data_wb_in1, (i < 3), exp_a[i], exp_d[i]);
            end
        end
        checks++; if (bus.WB_overflow !== 1'b1) begin failures++; $display("FAIL fill_sticky got=%b exp=1", bus.WB_overflow); end
    endtask

    task automatic test_reset_mid();
        push_alu(5'd7, 32'h77);
        push_ld(5'd8, 32'h88);
        step();
        push_alu(5'd9, 32'h99);
        push_ld(5'd10, 32'hAA);
        step();
        idle();
        checks++; if (bus.WB_count !== 3'd3) begin failures++; $display("FAIL rmid_fill got=%0d exp=3", bus.WB_count); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.REG_write_1 !== 1'b0) begin failures++; $display("FAIL rmid_write got=%b exp=0", bus.REG_write_1); end
        checks++; if (bus.WB_count !== 3'd0) begin failures++; $display("FAIL rmid_count got=%0d exp=0", bus.WB_count); end
        checks++; if (bus.WB_overflow !== 1'b0) begin failures++; $display("FAIL rmid_overflow got=%b exp=0", bus.WB_overflow); end
        step();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (bus.REG_write_1 !== 1'b0 || bus.WB_count !== 3'd0) begin
                failures++;
                $display("FAIL rmid_after_%0d got=%b/%0d exp=0/0", i, bus.REG_write_1, bus.WB_count);
            end
        end
    endtask

    task automatic test_query_r7();
        push_alu(5'd7, 32'h77);
        bus.WB_q_addr_1 = 5'd7;
        bus.WB_q_addr_2 = 5'd8;
        step();
        idle();
        checks++; if (bus.WB_q_hit_1 !== BYP) begin failures++; $display("FAIL r7_hit got=%b exp=%b", bus.WB_q_hit_1, BYP); end
        checks++; if (bus.WB_q_data_1 !== (BYP ? 32'h77 : 32'd0)) begin failures++; $display("FAIL r7_data got=%h", bus.WB_q_data_1); end
        checks++; if (bus.WB_q_hit_2 !== 1'b0 || bus.WB_q_data_2 !== 32'd0) begin failures++; $display("FAIL r8_miss got=%b/%h exp=0/0", bus.WB_q_hit_2, bus.WB_q_data_2); end
        step();
        step();
        checks++; if (bus.WB_count !== 3'd0 || bus.REG_write_1 !== 1'b0) begin failures++; $display("FAIL r7_drain got=%0d/%b exp=0/0", bus.WB_count, bus.REG_write_1); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_single();
        test_dual_same_addr();
        test_addr_zero();
        test_fill_overflow();
        test_reset_mid();
        test_query_r7();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
